led_code_scheduler: RTL and testbench

LED_CODE_SCHEDULER -- requirements
Module: led_code_scheduler

---
 rtl/led_code_scheduler.sv | 163 ++++++++++++++++
 tb/tb_led_code_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_code_scheduler.sv
// Three-requester status LED scheduler: round-robin grants one requester at a time,
// blinks its pulse code (ON/OFF pulses plus a trailing gap) and shows a heartbeat when idle.
module led_code_scheduler #(
  parameter int TICK_DIV  = 50000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 1000,
  parameter int HB_TICKS  = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [11:0] code_cnt,
  output logic [2:0]  grant,
  output logic [2:0]  done,
  output logic        busy,
  output logic        sled
);

  localparam int PS_W   = $clog2(TICK_DIV);
  localparam int PH_MAX = (ON_TICKS > OFF_TICKS)
                          ? ((ON_TICKS  > GAP_TICKS) ? ON_TICKS  : GAP_TICKS)
                          : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int HB_W   = (HB_TICKS > 1) ? $clog2(HB_TICKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

  state_t          state;
  logic [PS_W-1:0] presc;
  logic [PH_W-1:0] phase_cnt;
  logic [PH_W-1:0] ph_last;
  logic [HB_W-1:0] hb_cnt;
  logic            hb_lvl;
  logic [3:0]      pulse_cnt;
  logic [3:0]      code_lat;
  logic [1:0]      owner;
  logic [1:0]      last;
  logic            tick;
  logic            phase_end;
  logic            win_vld;
  logic [1:0]      win_idx;
  logic [1:0]      cand;
  logic [3:0]      win_code;

  assign tick = (presc == PS_W'(TICK_DIV - 1));

  always_comb begin
    ph_last = '0;
    case (state)
      S_ON:    ph_last = PH_W'(ON_TICKS - 1);
      S_OFF:   ph_last = PH_W'(OFF_TICKS - 1);
      S_GAP:   ph_last = PH_W'(GAP_TICKS - 1);
      default: ph_last = '0;
    endcase
  end

  assign phase_end = tick && (phase_cnt == ph_last);

  // Round-robin: walk from the farthest candidate to the nearest so the one right after
  // the last owner overwrites everything else.
  always_comb begin
    win_vld = |req;
    win_idx = '0;
    cand    = '0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(last) + k) % 3);
      if (req[cand]) win_idx = cand;
    end
  end

  always_comb begin
    case (win_idx)
      2'd0:    win_code = code_cnt[3:0];
      2'd1:    win_code = code_cnt[7:4];
      default: win_code = code_cnt[11:8];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      grant     <= '0;
      done      <= '0;
      busy      <= 1'b0;
      sled      <= 1'b0;
      presc     <= '0;
      phase_cnt <= '0;
      pulse_cnt <= '0;
      hb_cnt    <= '0;
      hb_lvl    <= 1'b0;
      code_lat  <= '0;
      owner     <= '0;
      last      <= 2'd2;
    end else begin
      done  <= '0;
      presc <= tick ? '0 : presc + 1'b1;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            grant     <= 3'b001 << win_idx;
            owner     <= win_idx;
            busy      <= 1'b1;
            code_lat  <= (win_code == 4'd0) ? 4'd1 : win_code;
            pulse_cnt <= '0;
            phase_cnt <= '0;
            presc     <= '0;
            hb_cnt    <= '0;
            hb_lvl    <= 1'b0;
            sled      <= 1'b1;
            state     <= S_ON;
          end else if (tick) begin
            if (hb_cnt == HB_W'(HB_TICKS - 1)) begin
              hb_cnt <= '0;
              hb_lvl <= ~hb_lvl;
              sled   <= ~hb_lvl;
            end else begin
              hb_cnt <= hb_cnt + 1'b1;
            end
          end
        end
        S_ON: begin
          if (phase_end) begin
            phase_cnt <= '0;
            pulse_cnt <= pulse_cnt + 1'b1;
            sled      <= 1'b0;
            state     <= S_OFF;
          end else if (tick) begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_OFF: begin
          if (phase_end) begin
            phase_cnt <= '0;
            if (pulse_cnt == code_lat) begin
              state <= S_GAP;
            end else begin
              sled  <= 1'b1;
              state <= S_ON;
            end
          end else if (tick) begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (phase_end) begin
            phase_cnt <= '0;
            done      <= grant;
            grant     <= '0;
            busy      <= 1'b0;
            last      <= owner;
            sled      <= 1'b0;
            state     <= S_IDLE;
          end else if (tick) begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_code_scheduler.sv
// Scoreboard bench for led_code_scheduler: stimulus queues expected grants and code
// completions, a negedge monitor pops and compares them as the DUT produces them.
module tb_led_code_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [11:0] code_cnt;
  logic [2:0]  grant;
  logic [2:0]  done;
  logic        busy;
  logic        sled;

  led_code_scheduler #(
    .TICK_DIV (4),
    .ON_TICKS (2),
    .OFF_TICKS(2),
    .GAP_TICKS(3),
    .HB_TICKS (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .code_cnt(code_cnt),
    .grant   (grant),
    .done    (done),
    .busy    (busy),
    .sled    (sled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] who;
    int         lat;
    int         hi;
    int         pulses;
    int         tail;
  } done_exp_t;

  logic [2:0] gq[$];
  done_exp_t  dq[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // lat: cycles from grant rising to done; hi: lit cycles; tail: dark cycles before done
  task automatic expect_code(input logic [2:0] who, input int lat, input int hi, input int pulses);
    done_exp_t e;
    e.who    = who;
    e.lat    = lat;
    e.hi     = hi;
    e.pulses = pulses;
    e.tail   = 20;
    gq.push_back(who);
    dq.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 3'b000 && n < 200);
    if (done == 3'b000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done got 0 within 200 cycles, expected a pulse", name);
    end
  endtask

  // Monitor
  int         ncyc = 0;
  int         g_cyc = 0;
  int         hi_cnt = 0;
  int         pulse_seen = 0;
  int         tail_cnt = 0;
  logic       prev_sled = 1'b0;
  logic [2:0] prev_g = 3'b000;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_g = 3'b000;
    end else begin
      ncyc++;
      if (grant != 3'b000 && prev_g == 3'b000) begin
        if (gq.size() == 0) begin
          chk("grant_unexpected", int'(grant), 0);
        end else begin
          chk("grant_owner", int'(grant), int'(gq.pop_front()));
        end
        g_cyc      = ncyc;
        hi_cnt     = 0;
        pulse_seen = 0;
        tail_cnt   = 0;
        prev_sled  = 1'b0;
      end
      if (busy) begin
        if (sled) begin
          hi_cnt++;
          if (!prev_sled) pulse_seen++;
          tail_cnt = 0;
        end else begin
          tail_cnt++;
        end
        prev_sled = sled;
      end
      if (done != 3'b000) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", int'(done), 0);
        end else begin
          done_exp_t e;
          e = dq.pop_front();
          chk("done_owner", int'(done), int'(e.who));
          chk("done_latency", ncyc - g_cyc, e.lat);
          chk("lit_cycles", hi_cnt, e.hi);
          chk("pulse_count", pulse_seen, e.pulses);
          chk("dark_tail", tail_cnt, e.tail);
          chk("grant_at_done", int'(grant), 0);
          chk("busy_at_done", int'(busy), 0);
        end
      end
      prev_g = grant;
    end
  end

  int hb_k[5] = '{19, 20, 39, 40, 60};
  int hb_v[5] = '{0, 1, 1, 0, 1};

  initial begin
    rst_n    = 1'b0;
    req      = 3'b000;
    code_cnt = 12'h000;
    repeat (3) @(negedge clk);
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sled", int'(sled), 0);

    // Idle heartbeat after release
    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      for (int j = 0; j < 5; j++)
        if (k == hb_k[j]) chk($sformatf("hb_cycle_%0d", k), int'(sled), hb_v[j]);
    end

    // Three-pulse code; code_cnt changes after the latch must be ignored
    expect_code(3'b010, 60, 24, 3);
    code_cnt = 12'h030;
    req      = 3'b010;
    @(negedge clk);
    req      = 3'b000;
    code_cnt = 12'h090;
    wait_done("code3");

    // Zero count behaves as one pulse
    expect_code(3'b001, 28, 8, 1);
    code_cnt = 12'h000;
    req      = 3'b001;
    @(negedge clk);
    req      = 3'b000;
    wait_done("code0");

    // Owner drops req mid-code; code still completes
    expect_code(3'b001, 44, 16, 2);
    code_cnt = 12'h002;
    req      = 3'b001;
    @(negedge clk);
    repeat (5) @(negedge clk);
    req = 3'b000;
    wait_done("drop_req");

    // Reset in the middle of a code
    gq.push_back(3'b010);
    code_cnt = 12'h030;
    req      = 3'b010;
    @(negedge clk);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    req   = 3'b000;
    #1;
    chk("abort_grant", int'(grant), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_sled", int'(sled), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 19) chk("hb_restart_19", int'(sled), 0);
      if (k == 20) chk("hb_restart_20", int'(sled), 1);
    end

    // Requesters 0 and 2 held from reset alternate, starting with 0
    @(negedge clk);
    rst_n    = 1'b0;
    req      = 3'b101;
    code_cnt = 12'h101;
    expect_code(3'b001, 28, 8, 1);
    expect_code(3'b100, 28, 8, 1);
    expect_code(3'b001, 28, 8, 1);
    expect_code(3'b100, 28, 8, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) wait_done($sformatf("rr_%0d", i));
    req = 3'b000;
    repeat (10) @(negedge clk);
    chk("grants_left", gq.size(), 0);
    chk("dones_left", dq.size(), 0);
    chk("idle_grant", int'(grant), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
